// File: rtl/cle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cle_pkg
// Description : Shared definitions for the connected-component labelling
//               engine and its relabel post-processing stage: scan FSM
//               state encoding and image geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package cle_pkg;

    // Image geometry: 32x32 pixels, raster addressed as {row, col}.
    localparam int IMG_DIM  = 32;
    localparam int NPIX     = IMG_DIM * IMG_DIM;
    // Label value reserved for background pixels.
    localparam int BG_LABEL = 0;

    // Relabel scan FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_WAIT = 3'd3,
        ST_EVAL = 3'd4,
        ST_WR   = 3'd5,
        ST_NEXT = 3'd6,
        ST_FIN  = 3'd7
    } state_t;

endpackage : cle_pkg
`default_nettype wire

// File: rtl/cle_label_map.sv
`default_nettype none
// ============================================================================
// Module      : cle_label_map
// Description : Old-label -> new-label translation table, 2**DATA_W entries,
//               each with a valid bit.
//   clk, reset      : clock, asynchronous active-low reset (valid bits only)
//   clr             : clears every valid bit in one cycle
//   lookup_key      : label to translate (combinational lookup)
//   hit, value      : lookup result; value is meaningful only when hit=1
//   ins, ins_key,
//   ins_val         : one-cycle insert of ins_key -> ins_val, marked valid
// Revision    : 1.0 - initial release
// ============================================================================
module cle_label_map #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [DATA_W-1:0] lookup_key,
    output logic              hit,
    output logic [DATA_W-1:0] value,
    input  logic              ins,
    input  logic [DATA_W-1:0] ins_key,
    input  logic [DATA_W-1:0] ins_val
);

    localparam int DEPTH = 2 ** DATA_W;

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_val [DEPTH];

    // Only the valid bits need a reset/clear; stale values behind a cleared
    // valid bit are never observed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (clr) begin
            r_valid <= '0;
        end else if (ins) begin
            r_valid[ins_key] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ins) begin
            r_val[ins_key] <= ins_val;
        end
    end

    assign hit   = r_valid[lookup_key];
    assign value = r_val[lookup_key];

endmodule : cle_label_map
`default_nettype wire

// File: rtl/cle_relabel.sv
`default_nettype none
// ============================================================================
// Module      : cle_relabel
// Description : Rewrites the 32x32 label SRAM in place so that components
//               are numbered 1..N in raster order of first appearance and
//               reports N. Background (label 0) pixels are never written.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : single-cycle start pulse, ignored while busy
//   sram_q      : SRAM read data (one-cycle synchronous read latency)
//   sram_a/d    : registered SRAM address / write data
//   sram_wen    : registered SRAM write enable, active-low
//   busy, done  : scan in progress / scan complete (held until next start)
//   comp_count  : number of distinct nonzero labels, valid while done=1
// Revision    : 1.0 - initial release
// ============================================================================
module cle_relabel
    import cle_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] sram_q,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_wen,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] comp_count
);

    localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [DATA_W-1:0] c_BG       = DATA_W'(BG_LABEL);
    localparam logic [DATA_W:0]   c_FIRST    = (DATA_W + 1)'(1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    // One bit wider than a label: with 255 distinct labels it reaches 256.
    logic [DATA_W:0]   r_next_label, w_label_nxt;
    logic [ADDR_W-1:0] r_sram_a, w_a_nxt;
    logic [DATA_W-1:0] r_sram_d, w_d_nxt;
    logic              r_sram_wen, w_wen_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [DATA_W-1:0] r_comp_count, w_count_nxt;

    logic              w_map_clr;
    logic              w_map_ins;
    logic              w_map_hit;
    logic [DATA_W-1:0] w_map_val;
    logic [DATA_W-1:0] w_new_label;

    cle_label_map #(
        .DATA_W (DATA_W)
    ) u_map (
        .clk        (clk),
        .reset      (reset),
        .clr        (w_map_clr),
        .lookup_key (sram_q),
        .hit        (w_map_hit),
        .value      (w_map_val),
        .ins        (w_map_ins),
        .ins_key    (sram_q),
        .ins_val    (r_next_label[DATA_W-1:0])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_next_label <= c_FIRST;
            r_sram_a     <= '0;
            r_sram_d     <= '0;
            r_sram_wen   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_comp_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_next_label <= w_label_nxt;
            r_sram_a     <= w_a_nxt;
            r_sram_d     <= w_d_nxt;
            r_sram_wen   <= w_wen_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_comp_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_label_nxt = r_next_label;
        w_a_nxt     = r_sram_a;
        w_d_nxt     = r_sram_d;
        w_wen_nxt   = 1'b1;          // write strobe lasts one cycle at most
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_count_nxt = r_comp_count;
        w_map_clr   = 1'b0;
        w_map_ins   = 1'b0;
        // New label for the pixel under evaluation: existing mapping, or the
        // next unused label if this old label has not been seen yet.
        w_new_label = w_map_hit ? w_map_val : r_next_label[DATA_W-1:0];

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CLR;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_CLR: begin
                w_map_clr   = 1'b1;
                w_cnt_nxt   = '0;
                w_label_nxt = c_FIRST;
                w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                w_a_nxt     = r_cnt;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                w_state_nxt = ST_NEXT;
                if (sram_q != c_BG) begin
                    if (!w_map_hit) begin
                        w_map_ins   = 1'b1;
                        w_label_nxt = r_next_label + c_FIRST;
                    end
                    // Pixels whose label is already correct are not rewritten.
                    if (w_new_label != sram_q) begin
                        w_d_nxt     = w_new_label;
                        w_wen_nxt   = 1'b0;
                        w_state_nxt = ST_WR;
                    end
                end
            end
            ST_WR: begin
                w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_cnt == c_LAST_PIX) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_FIN: begin
                w_count_nxt = DATA_W'(r_next_label - c_FIRST);
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sram_a     = r_sram_a;
    assign sram_d     = r_sram_d;
    assign sram_wen   = r_sram_wen;
    assign busy       = r_busy;
    assign done       = r_done;
    assign comp_count = r_comp_count;

endmodule : cle_relabel
`default_nettype wire

// File: tb/tb_cle_relabel.sv
`default_nettype none
// ============================================================================
// Module      : tb_cle_relabel
// Description : Self-checking bench for cle_relabel. A synchronous SRAM
//               model holds the image; a reference model computes the
//               expected relabelled image, write sequence, component count
//               and latency from the image alone.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cle_relabel;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int NPIX   = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] sram_q;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic              sram_wen;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] comp_count;

    always #5 clk = ~clk;

    cle_relabel #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sram_q     (sram_q),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_wen   (sram_wen),
        .busy       (busy),
        .done       (done),
        .comp_count (comp_count)
    );

    // ---------------- SRAM model (single writer process) ----------------
    logic [DATA_W-1:0] mem     [NPIX];
    logic [DATA_W-1:0] img_buf [NPIX];
    logic              load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            mem <= img_buf;
        end else begin
            sram_q <= mem[sram_a];
            if (!sram_wen) mem[sram_a] <= sram_d;
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_img [NPIX];
    logic [17:0]       exp_wq  [$];     // {addr, data} in write order
    int                exp_count;
    int                exp_nwr;

    // Components numbered in raster order of first appearance.
    task automatic build_expected();
        int lut [256];
        int nxt;
        for (int i = 0; i < 256; i++) lut[i] = -1;
        nxt = 1;
        exp_nwr = 0;
        exp_wq.delete();
        for (int p = 0; p < NPIX; p++) begin
            int v;
            v = int'(img_buf[p]);
            exp_img[p] = img_buf[p];
            if (v != 0) begin
                if (lut[v] < 0) begin
                    lut[v] = nxt;
                    nxt++;
                end
                exp_img[p] = DATA_W'(lut[v]);
                if (lut[v] != v) begin
                    exp_wq.push_back({ADDR_W'(p), DATA_W'(lut[v])});
                    exp_nwr++;
                end
            end
        end
        exp_count = nxt - 1;
    endtask

    // ---------------- compare process: every write strobe ----------------
    always @(negedge clk) begin
        if (reset && !sram_wen) begin
            if (exp_wq.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                logic [17:0] e;
                e = exp_wq.pop_front();
                chk("write_addr", int'(sram_a), int'(e[17:8]));
                chk("write_data", int'(sram_d), int'(e[7:0]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_img();
        build_expected();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic clear_img();
        for (int p = 0; p < NPIX; p++) img_buf[p] = '0;
    endtask

    // Pulses start and waits for done. glitch_at: cycle at which a second
    // start pulse is applied (-1 = none). abort_at: cycle at which reset is
    // asserted mid-scan (-1 = none); returns with lat = -1 in that case.
    task automatic run_scan(input int glitch_at, input int abort_at, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
        lat = 0;
        while (!done && lat < 7000) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == glitch_at) ? 1'b1 : 1'b0;
            if (glitch_at >= 0 && lat == glitch_at + 2)
                chk("busy_after_glitch", int'(busy), 1);
            if (lat == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_sram_a", int'(sram_a), 0);
                chk("abort_sram_d", int'(sram_d), 0);
                chk("abort_sram_wen", int'(sram_wen), 1);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_count", int'(comp_count), 0);
                @(negedge clk);
                reset = 1'b1;
                exp_wq.delete();
                lat = -1;
                return;
            end
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int lat);
        int diffs;
        chk({tag, "_count"}, int'(comp_count), exp_count);
        chk({tag, "_latency"}, lat, 4098 + exp_nwr);
        chk({tag, "_busy_low"}, int'(busy), 0);
        chk({tag, "_writes_left"}, exp_wq.size(), 0);
        diffs = 0;
        for (int p = 0; p < NPIX; p++)
            if (mem[p] !== exp_img[p]) diffs++;
        chk({tag, "_mem_diffs"}, diffs, 0);
    endtask

    task automatic rand_img(input int nlab);
        logic [DATA_W-1:0] labs [20];
        for (int i = 0; i < nlab; i++) labs[i] = DATA_W'($urandom_range(1, 255));
        for (int p = 0; p < NPIX; p++)
            img_buf[p] = ($urandom_range(0, 9) < 6) ? '0 : labs[$urandom_range(0, nlab - 1)];
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        reset = 1'b0;
        start = 1'b0;
        clear_img();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sram_a", int'(sram_a), 0);
        chk("rst_sram_d", int'(sram_d), 0);
        chk("rst_sram_wen", int'(sram_wen), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(comp_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // All background: no writes, minimum latency.
        clear_img();
        load_img();
        chk("model_zero_count", exp_count, 0);
        run_scan(-1, -1, lat);
        chk("zero_latency_lit", lat, 4098);
        chk("zero_count_lit", int'(comp_count), 0);
        check_result("zero", lat);

        // Whole image labelled 7: every pixel rewritten to 1.
        for (int p = 0; p < NPIX; p++) img_buf[p] = 8'd7;
        load_img();
        chk("model_all7_nwr", exp_nwr, 1024);
        run_scan(-1, -1, lat);
        chk("all7_latency_lit", lat, 5122);
        chk("all7_count_lit", int'(comp_count), 1);
        check_result("all7", lat);

        // Sparse: (0,31)=200, (5,3)=5, (9,9)=200.
        clear_img();
        img_buf[31] = 8'd200;
        img_buf[5*32+3] = 8'd5;
        img_buf[9*32+9] = 8'd200;
        load_img();
        run_scan(-1, -1, lat);
        chk("sparse_px0_31", int'(mem[31]), 1);
        chk("sparse_px5_3", int'(mem[5*32+3]), 2);
        chk("sparse_px9_9", int'(mem[9*32+9]), 1);
        chk("sparse_count_lit", int'(comp_count), 2);
        check_result("sparse", lat);

        // (0,0)=1 unchanged, (1,0)=3 -> 2: exactly one write.
        clear_img();
        img_buf[0]  = 8'd1;
        img_buf[32] = 8'd3;
        load_img();
        chk("model_pair_nwr", exp_nwr, 1);
        run_scan(-1, -1, lat);
        chk("pair_px0", int'(mem[0]), 1);
        chk("pair_px32", int'(mem[32]), 2);
        chk("pair_latency_lit", lat, 4099);
        check_result("pair", lat);

        // 255 distinct labels placed in reverse raster order: count boundary.
        clear_img();
        for (int v = 1; v < 256; v++) img_buf[1023 - 4*v] = DATA_W'(v);
        img_buf[1] = 8'd9;
        load_img();
        run_scan(-1, -1, lat);
        chk("max_count_lit", int'(comp_count), 255);
        check_result("max", lat);

        // Second start 100 cycles into a scan must be ignored.
        rand_img(8);
        load_img();
        run_scan(100, -1, lat);
        check_result("glitch", lat);

        // Reset mid-scan, then a clean run on fresh data.
        rand_img(5);
        load_img();
        run_scan(-1, 150, lat);
        rand_img(12);
        load_img();
        run_scan(-1, -1, lat);
        check_result("after_abort", lat);

        // Randomized images.
        for (int r = 0; r < 3; r++) begin
            rand_img($urandom_range(1, 20));
            load_img();
            run_scan(-1, -1, lat);
            check_result("random", lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cle_relabel
`default_nettype wire
